// File: rtl/switches_pio_debounced_if.sv
// Avalon-MM slave bus for the debounced switch PIO.
// The CPU side uses master; the PIO uses slave.
interface switches_pio_debounced_if #(
    parameter int WIDTH = 9
) ();
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [WIDTH-1:0] writedata;
    logic [WIDTH-1:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/switches_pio_debounced.sv
// Switch/button input PIO: synchroniser, per-bit debouncer, edge capture,
// interrupt mask, and a level interrupt. Register reads have one cycle of latency.
module switches_pio_debounced #(
    parameter int WIDTH           = 9,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int EDGE_MODE       = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    switches_pio_debounced_if.slave  bus,
    input  logic [WIDTH-1:0]         in_port,
    output logic                     irq
);
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        REG_DATA = 2'd0,
        REG_RSVD = 2'd1,
        REG_MASK = 2'd2,
        REG_EDGE = 2'd3
    } reg_addr_e;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [CNT_W-1:0] cnt_q  [WIDTH];
    logic [CNT_W-1:0] cnt_d  [WIDTH];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] accept, ev, clear;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             wr_en;

    assign sync  = sync_q[SYNC_STAGES-1];
    assign wr_en = bus.chipselect && !bus.write_n;

    // A bit is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        // NOTE: every output gets a default first so no path through the loop can infer a latch.
        stable_d = stable_q;
        accept   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    accept[i]   = 1'b1;
                    stable_d[i] = sync[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        if (EDGE_MODE == 0)      ev = accept & sync;
        else if (EDGE_MODE == 1) ev = accept & ~sync;
        else                     ev = accept;
    end

    always_comb begin
        irqmask_d = irqmask_q;
        clear     = '0;
        if (wr_en && reg_addr_e'(bus.address) == REG_MASK) irqmask_d = bus.writedata;
        if (wr_en && reg_addr_e'(bus.address) == REG_EDGE) clear     = bus.writedata;
        // Set wins over a same-cycle clear so no edge is ever lost.
        edgecap_d = ev | (edgecap_q & ~clear);

        rdata_d = '0;
        case (reg_addr_e'(bus.address))
            REG_DATA: rdata_d = stable_q;
            REG_MASK: rdata_d = irqmask_q;
            REG_EDGE: rdata_d = edgecap_q;
            default:  rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the per-bit arrays are reset too, so a reset mid-debounce leaves no partial count or stale sample.
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            for (int i = 0; i < WIDTH; i++)       cnt_q[i]  <= '0;
            stable_q  <= '0;
            irqmask_q <= '0;
            edgecap_q <= '0;
            rdata_q   <= '0;
        end else begin
            // NOTE: non-blocking so each stage takes its predecessor's pre-edge value; blocking would collapse the chain.
            sync_q[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            for (int i = 0; i < WIDTH; i++)       cnt_q[i]  <= cnt_d[i];
            stable_q  <= stable_d;
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus.readdata = rdata_q;
    assign irq          = |(edgecap_q & irqmask_q);
endmodule

// File: tb/tb_switches_pio_debounced.sv
// Bench for switches_pio_debounced: three instances (rising, falling, any edge) share
// one stimulus stream and are compared against a window-based reference model.
module tb_switches_pio_debounced;
    localparam int W   = 9;
    localparam int SS  = 2;
    localparam int DEB = 4;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] in_port;
    logic [1:0]   address;
    logic         cs;
    logic         wn;
    logic [W-1:0] wd;
    logic         irq0, irq1, irq2;
    logic [W-1:0] rd    [3];
    logic         irq_v [3];
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    switches_pio_debounced_if #(.WIDTH(W)) bus0 ();
    switches_pio_debounced_if #(.WIDTH(W)) bus1 ();
    switches_pio_debounced_if #(.WIDTH(W)) bus2 ();

    assign bus0.address = address; assign bus0.chipselect = cs; assign bus0.write_n = wn; assign bus0.writedata = wd;
    assign bus1.address = address; assign bus1.chipselect = cs; assign bus1.write_n = wn; assign bus1.writedata = wd;
    assign bus2.address = address; assign bus2.chipselect = cs; assign bus2.write_n = wn; assign bus2.writedata = wd;
    assign rd[0] = bus0.readdata; assign rd[1] = bus1.readdata; assign rd[2] = bus2.readdata;
    assign irq_v[0] = irq0; assign irq_v[1] = irq1; assign irq_v[2] = irq2;

    switches_pio_debounced #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DEB), .EDGE_MODE(0)) u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave), .in_port(in_port), .irq(irq0));
    switches_pio_debounced #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DEB), .EDGE_MODE(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave), .in_port(in_port), .irq(irq1));
    switches_pio_debounced #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DEB), .EDGE_MODE(2)) u_dut2 (
        .clk(clk), .reset(reset), .bus(bus2.slave), .in_port(in_port), .irq(irq2));

    // Reference model: in_port delayed by SS samples, then a bit is accepted when every
    // sample in the last DEB-sample window differs from its stable value.
    logic [W-1:0] m_dl   [SS];
    logic [W-1:0] m_win  [DEB];
    logic [W-1:0] m_ecap [3];
    logic [W-1:0] m_rd   [3];
    logic [W-1:0] m_stable, m_mask;

    task automatic model_reset();
        for (int j = 0; j < SS; j++)  m_dl[j]  = '0;
        for (int j = 0; j < DEB; j++) m_win[j] = '0;
        for (int k = 0; k < 3; k++) begin m_ecap[k] = '0; m_rd[k] = '0; end
        m_stable = '0;
        m_mask   = '0;
    endtask

    // Advances the model by the clock edge about to happen, using the inputs now applied.
    task automatic model_step();
        logic [W-1:0] acc, nst, clr;
        logic [W-1:0] ev [3];
        if (reset) begin
            model_reset();
            return;
        end
        for (int j = DEB-1; j > 0; j--) m_win[j] = m_win[j-1];
        m_win[0] = m_dl[SS-1];
        acc = '1;
        for (int j = 0; j < DEB; j++) acc = acc & (m_win[j] ^ m_stable);
        nst   = m_stable ^ acc;
        ev[0] = acc & nst;
        ev[1] = acc & ~nst;
        ev[2] = acc;
        clr   = (cs && !wn && address == 2'd3) ? wd : '0;
        for (int k = 0; k < 3; k++) begin
            case (address)
                2'd0:    m_rd[k] = m_stable;
                2'd2:    m_rd[k] = m_mask;
                2'd3:    m_rd[k] = m_ecap[k];
                default: m_rd[k] = '0;
            endcase
            m_ecap[k] = ev[k] | (m_ecap[k] & ~clr);
        end
        if (cs && !wn && address == 2'd2) m_mask = wd;
        for (int j = SS-1; j > 0; j--) m_dl[j] = m_dl[j-1];
        m_dl[0]  = in_port;
        m_stable = nst;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic bus_idle();
        cs = 1'b0; wn = 1'b1; wd = '0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [W-1:0] d);
        address = a; cs = 1'b1; wn = 1'b0; wd = d;
        tick();
        bus_idle();
    endtask

    task automatic read_reg(input logic [1:0] a);
        address = a;
        tick();
    endtask

    task automatic test_reset();
        logic [W-1:0] exp [3];
        in_port = '1; address = 2'd0; bus_idle();
        reset = 1'b1; model_reset();
        ticks(2);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rd[k] !== '0 || irq_v[k] !== 1'b0) begin
                errors++; $display("FAIL reset_state m%0d: readdata=%h irq=%b expected 0/0", k, rd[k], irq_v[k]);
            end
        end
        for (int a = 0; a < 4; a++) begin
            read_reg(2'(a));
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (rd[k] !== '0 || rd[k] !== m_rd[k]) begin
                    errors++; $display("FAIL reset_read a%0d m%0d: readdata=%h expected=0 model=%h", a, k, rd[k], m_rd[k]);
                end
            end
        end
        address = 2'd0;
        ticks(2);
        checks++;
        if (rd[0] !== '0) begin
            errors++; $display("FAIL powerup_edge6 m0: readdata=%h expected=000", rd[0]);
        end
        tick();
        read_reg(2'd3);
        exp[0] = 9'h1FF; exp[1] = 9'h000; exp[2] = 9'h1FF;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rd[k] !== exp[k] || rd[k] !== m_rd[k]) begin
                errors++; $display("FAIL powerup_capture m%0d: readdata=%h expected=%h model=%h", k, rd[k], exp[k], m_rd[k]);
            end
        end
        bus_write(2'd3, '1);
    endtask

    task automatic test_glitch();
        logic [W-1:0] exp [3];
        in_port = '0;
        ticks(8);
        bus_write(2'd3, '1);
        in_port[2] = 1'b1; ticks(3);
        in_port[2] = 1'b0; ticks(8);
        read_reg(2'd0);
        read_reg(2'd3);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rd[k] !== '0 || rd[k] !== m_rd[k]) begin
                errors++; $display("FAIL glitch_reject m%0d: edgecapture=%h expected=000 model=%h", k, rd[k], m_rd[k]);
            end
        end
        address = 2'd0;
        in_port[2] = 1'b1;
        ticks(6);
        checks++;
        if (rd[0] !== 9'h000) begin
            errors++; $display("FAIL hold_edge6 m0: readdata=%h expected=000", rd[0]);
        end
        tick();
        checks++;
        if (rd[0] !== 9'h004 || rd[0] !== m_rd[0]) begin
            errors++; $display("FAIL hold_data m0: readdata=%h expected=004 model=%h", rd[0], m_rd[0]);
        end
        read_reg(2'd3);
        exp[0] = 9'h004; exp[1] = 9'h000; exp[2] = 9'h004;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rd[k] !== exp[k] || rd[k] !== m_rd[k]) begin
                errors++; $display("FAIL hold_capture m%0d: edgecapture=%h expected=%h model=%h", k, rd[k], exp[k], m_rd[k]);
            end
        end
    endtask

    task automatic test_irq();
        logic exp [3];
        bus_write(2'd2, 9'h004);
        exp[0] = 1'b1; exp[1] = 1'b0; exp[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (irq_v[k] !== exp[k]) begin
                errors++; $display("FAIL irq_mask_set m%0d: irq=%b expected=%b", k, irq_v[k], exp[k]);
            end
        end
        bus_write(2'd3, 9'h004);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (irq_v[k] !== 1'b0) begin
                errors++; $display("FAIL irq_clear m%0d: irq=%b expected=0", k, irq_v[k]);
            end
        end
        in_port[2] = 1'b0; ticks(8);
        bus_write(2'd3, '1);
        in_port[2] = 1'b1; ticks(8);
        bus_write(2'd3, 9'h000);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (irq_v[k] !== exp[k] || irq_v[k] !== (|(m_ecap[k] & m_mask))) begin
                errors++; $display("FAIL irq_zero_write m%0d: irq=%b expected=%b", k, irq_v[k], exp[k]);
            end
        end
        bus_write(2'd3, '1);
        bus_write(2'd2, '0);
    endtask

    task automatic test_collision();
        logic [W-1:0] exp [3];
        in_port[5] = 1'b1;
        ticks(5);
        address = 2'd3; cs = 1'b1; wn = 1'b0; wd = 9'h020;
        tick();
        bus_idle();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rd[k] !== 9'h000 || rd[k] !== m_rd[k]) begin
                errors++; $display("FAIL collide_pre_read m%0d: edgecapture=%h expected=000 model=%h", k, rd[k], m_rd[k]);
            end
        end
        tick();
        exp[0] = 9'h020; exp[1] = 9'h000; exp[2] = 9'h020;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rd[k] !== exp[k] || rd[k] !== m_rd[k]) begin
                errors++; $display("FAIL collide_set_wins m%0d: edgecapture=%h expected=%h model=%h", k, rd[k], exp[k], m_rd[k]);
            end
        end
        bus_write(2'd3, '1);
    endtask

    task automatic test_modes();
        logic [W-1:0] exp [3];
        in_port[0] = 1'b1; ticks(8);
        read_reg(2'd3);
        exp[0] = 9'h001; exp[1] = 9'h000; exp[2] = 9'h001;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rd[k] !== exp[k] || rd[k] !== m_rd[k]) begin
                errors++; $display("FAIL mode_rise m%0d: edgecapture=%h expected=%h model=%h", k, rd[k], exp[k], m_rd[k]);
            end
        end
        bus_write(2'd3, '1);
        in_port[0] = 1'b0; ticks(8);
        read_reg(2'd3);
        exp[0] = 9'h000; exp[1] = 9'h001; exp[2] = 9'h001;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rd[k] !== exp[k] || rd[k] !== m_rd[k]) begin
                errors++; $display("FAIL mode_fall m%0d: edgecapture=%h expected=%h model=%h", k, rd[k], exp[k], m_rd[k]);
            end
        end
        bus_write(2'd3, '1);
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] exp [3];
        in_port[7] = 1'b1;
        ticks(4);
        reset = 1'b1; model_reset();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rd[k] !== '0 || irq_v[k] !== 1'b0) begin
                errors++; $display("FAIL midreset_state m%0d: readdata=%h irq=%b expected 0/0", k, rd[k], irq_v[k]);
            end
        end
        tick();
        reset = 1'b0;
        address = 2'd0;
        ticks(6);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rd[k] !== 9'h000 || rd[k] !== m_rd[k]) begin
                errors++; $display("FAIL midreset_early m%0d: readdata=%h expected=000 model=%h", k, rd[k], m_rd[k]);
            end
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rd[k] !== 9'h0A4 || rd[k] !== m_rd[k]) begin
                errors++; $display("FAIL midreset_accept m%0d: readdata=%h expected=0a4 model=%h", k, rd[k], m_rd[k]);
            end
        end
        read_reg(2'd3);
        exp[0] = 9'h0A4; exp[1] = 9'h000; exp[2] = 9'h0A4;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rd[k] !== exp[k] || rd[k] !== m_rd[k]) begin
                errors++; $display("FAIL midreset_capture m%0d: edgecapture=%h expected=%h model=%h", k, rd[k], exp[k], m_rd[k]);
            end
        end
        bus_write(2'd3, '1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) in_port[$urandom_range(0, W-1)] ^= 1'b1;
            address = 2'($urandom_range(0, 3));
            cs      = 1'($urandom_range(0, 1));
            wn      = 1'($urandom_range(0, 1));
            wd      = W'($urandom);
            if (i == 200) begin
                reset = 1'b1; model_reset();
                tick();
                reset = 1'b0;
            end else begin
                tick();
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (rd[k] !== m_rd[k] || irq_v[k] !== (|(m_ecap[k] & m_mask))) begin
                    errors++;
                    $display("FAIL random c%0d m%0d: readdata=%h irq=%b model readdata=%h irq=%b",
                             i, k, rd[k], irq_v[k], m_rd[k], |(m_ecap[k] & m_mask));
                end
            end
        end
        bus_idle();
    endtask

    initial begin
        in_port = '0;
        address = 2'd0;
        bus_idle();
        test_reset();
        test_glitch();
        test_irq();
        test_collision();
        test_modes();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
